// File: rtl/mod461_serial_reducer_if.sv
// Handshake bundle for mod461_serial_reducer: operand in, residue out, busy status.
interface mod461_serial_reducer_if #(
  parameter int unsigned N_BITS = 300
);
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS:1]   in_x;
  logic              out_valid;
  logic              out_ready;
  logic [8:0]        out_r;
  logic              busy;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_r, busy
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_r, busy
  );
endinterface

// File: rtl/mod461_serial_reducer.sv
// Serial X mod 461: walks the operand 9 bits per cycle, MS chunk first (Horner, 2^9 = 51 mod 461).
// Optional MOD461_SKIP_ZERO_EN: start from the highest nonzero chunk to shorten latency.
module mod461_serial_reducer #(
  parameter int unsigned N_BITS = 300
) (
  input  logic                    clk,
  input  logic                    rst,
  mod461_serial_reducer_if.slave  bus
);

  localparam int unsigned NC  = (N_BITS + 8) / 9;
  localparam int unsigned SW  = NC * 9;
  localparam int unsigned CW  = $clog2(NC);
  localparam int unsigned TW  = 15;
  localparam int unsigned F1W = 12;
  localparam int unsigned F2W = 10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   sreg;
  logic [CW-1:0]   cnt;
  logic [8:0]      acc;
  logic [8:0]      acc_nxt;
  logic [8:0]      chunk;
  logic [TW-1:0]   t;
  logic [F1W-1:0]  fold1;
  logic [F2W-1:0]  fold2;
  logic [SW-1:0]   x_pad;
  logic [SW-1:0]   load_sreg;
  logic [CW-1:0]   load_cnt;
  logic            in_ready;
  logic            out_valid;
  logic            busy;

  assign x_pad = SW'(bus.in_x);

  // Load alignment: the chunk to start from must sit at the top of the shift register.
`ifdef MOD461_SKIP_ZERO_EN
  logic [CW-1:0]   top_idx;
  int unsigned     shamt;

  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      if (x_pad[9*i +: 9] != 9'd0) top_idx = CW'(i);
    end
    shamt     = 9 * (NC - 1 - 32'(top_idx));
    load_sreg = x_pad << shamt;
    load_cnt  = top_idx;
  end
`else
  assign load_sreg = x_pad;
  assign load_cnt  = CW'(NC - 1);
`endif

  // One Horner step, fully reduced: two 2^9 folds then one conditional subtract.
  always_comb begin
    chunk   = sreg[SW-1 -: 9];
    t       = TW'(acc) * TW'(51) + TW'(chunk);
    fold1   = F1W'(t[TW-1:9]) * F1W'(51) + F1W'(t[8:0]);
    fold2   = F2W'(fold1[F1W-1:9]) * F2W'(51) + F2W'(fold1[8:0]);
    acc_nxt = (fold2 >= F2W'(461)) ? 9'(fold2 - F2W'(461)) : fold2[8:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (cnt == '0)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      acc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg <= load_sreg;
            cnt  <= load_cnt;
            acc  <= '0;
          end
        end
        RUN: begin
          sreg <= {sreg[SW-10:0], 9'd0};
          acc  <= acc_nxt;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.out_r     = acc;

endmodule

// File: tb/tb_mod461_serial_reducer.sv
// Bench for mod461_serial_reducer: bit-serial bigint reference model plus directed and random operands.
module tb_mod461_serial_reducer;

  localparam int unsigned N  = 300;
  localparam int unsigned NC = (N + 8) / 9;
`ifdef MOD461_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk;
  logic rst;
  int unsigned n_chk;
  int unsigned n_fail;

  mod461_serial_reducer_if #(.N_BITS(N)) bus ();

  mod461_serial_reducer #(.N_BITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference residue: one bit at a time, MSB first.
  function automatic int unsigned mod_ref(input logic [N-1:0] x);
    int unsigned r = 0;
    for (int i = int'(N) - 1; i >= 0; i--) r = (r * 2 + 32'(x[i])) % 461;
    return r;
  endfunction

  // Latency when leading zero chunks are skipped.
  function automatic int unsigned lat_skip(input logic [N-1:0] x);
    int unsigned h = 0;
    for (int i = 0; i < int'(N); i++) if (x[i]) h = i;
    return h / 9 + 1;
  endfunction

  function automatic int unsigned exp_lat(input logic [N-1:0] x);
    return SKIP ? lat_skip(x) : NC;
  endfunction

  function automatic logic [N-1:0] rnd_x();
    logic [319:0] w;
    for (int i = 0; i < 10; i++) w[32*i +: 32] = $urandom;
    return w[N-1:0] >> $urandom_range(0, N - 1);
  endfunction

  // Cycle model: tracks which operand is in flight and when its residue is due.
  bit          m_busy, m_acc_nxt, m_rel_nxt, m_stalled, m_valid;
  int unsigned m_edges, m_lat, m_exp, m_prev_r;
  logic [N-1:0] m_pend;

  always @(negedge clk) begin
    if (rst) begin
      m_busy    = 1'b0;
      m_acc_nxt = 1'b0;
      m_rel_nxt = 1'b0;
      m_stalled = 1'b0;
      chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_busy",      32'(bus.busy),      32'd0);
      chk("reset_out_r",     32'(bus.out_r),     32'd0);
    end else begin
      if (m_acc_nxt) begin
        m_busy  = 1'b1;
        m_edges = 0;
        m_exp   = mod_ref(m_pend);
        m_lat   = exp_lat(m_pend);
      end else if (m_rel_nxt) begin
        m_busy = 1'b0;
      end else if (m_busy && m_edges < m_lat) begin
        m_edges++;
      end
      m_valid = m_busy && (m_edges == m_lat);
      chk("in_ready",  32'(bus.in_ready),  32'(!m_busy));
      chk("busy",      32'(bus.busy),      32'(m_busy));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_r", 32'(bus.out_r), m_exp);
        if (m_stalled) chk("out_r_stable", 32'(bus.out_r), m_prev_r);
      end
      m_stalled = m_valid && !bus.out_ready;
      m_prev_r  = 32'(bus.out_r);
      m_acc_nxt = !m_busy && bus.in_valid;
      m_pend    = bus.in_x;
      m_rel_nxt = m_valid && bus.out_ready;
    end
  end

  // One operation; use_lit selects hand-computed residue/latency (lit_lat applies to the skip build).
  task automatic run_op(input logic [N-1:0] x, input bit stall, input bit toggle,
                        input bit use_lit, input int unsigned lit_r, input int unsigned lit_lat);
    int unsigned lat;
    int unsigned r;
    bit hs;
    for (int c = 0; c < 50 && !bus.in_ready; c++) begin @(posedge clk); #1; end
    chk("ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_x     = rnd_x();
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      if (toggle) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_x     = rnd_x();
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
    hs = 1'b0;
    r  = 0;
    for (int c = 0; c < 200 && !hs; c++) begin
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = bus.out_valid && bus.out_ready;
      r  = 32'(bus.out_r);
      @(posedge clk); #1;
    end
    bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b0;
    chk("handshake_done", 32'(hs), 32'd1);
    if (use_lit) begin
      chk("residue_literal", r, lit_r);
      chk("latency_literal", lat, SKIP ? lit_lat : 32'd34);
    end else begin
      chk("residue_model", r, mod_ref(x));
      chk("latency_model", lat, exp_lat(x));
    end
  endtask

  task automatic back_to_back();
    logic [N-1:0] ops [4];
    logic [N-1:0] prev;
    int unsigned cyc, last, n;
    bit a;
    ops[0] = '1;
    ops[1] = N'(460);
    ops[2] = N'(262144);
    ops[3] = rnd_x();
    cyc = 0; last = 0; n = 0; prev = '0;
    bus.out_ready = 1'b1;
    bus.in_x      = ops[0];
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 400 && n < 4; c++) begin
      a = bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (a) begin
        if (n > 0) chk("b2b_spacing", cyc - last, exp_lat(prev) + 2);
        prev = ops[n];
        last = cyc;
        n++;
        if (n < 4) bus.in_x = ops[n];
        else       bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", n, 32'd4);
    for (int c = 0; c < 100 && !bus.in_ready; c++) begin @(posedge clk); #1; end
    bus.out_ready = 1'b0;
  endtask

  task automatic reset_mid_run();
    logic [N-1:0] x;
    x = rnd_x();
    x[N-1] = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (17) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(N'(1), 1'b0, 1'b0, 1'b1, 1, 1);
  endtask

  initial begin
    logic [N-1:0] x;
    n_chk  = 0;
    n_fail = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Pin the reference model itself.
    chk("ref_460",    mod_ref(N'(460)), 460);
    chk("ref_461",    mod_ref(N'(461)), 0);
    chk("ref_512",    mod_ref(N'(512)), 51);
    chk("ref_2p18",   mod_ref(N'(262144)), 296);
    chk("ref_235980", mod_ref(N'(235980)), 409);
    chk("lat_skip_2p18", lat_skip(N'(262144)), 3);

    run_op(N'(460),    1'b0, 1'b0, 1'b1, 460, 1);
    run_op(N'(461),    1'b0, 1'b0, 1'b1, 0,   1);
    run_op(N'(512),    1'b0, 1'b0, 1'b1, 51,  2);
    run_op(N'(262144), 1'b0, 1'b0, 1'b1, 296, 3);
    run_op(N'(235980), 1'b1, 1'b0, 1'b1, 409, 2);
    run_op(N'(0),      1'b0, 1'b0, 1'b1, 0,   1);
    run_op('1,         1'b1, 1'b0, 1'b0, 0,   0);

    x = rnd_x();
    x[N-1] = 1'b1;
    run_op(x, 1'b1, 1'b1, 1'b0, 0, 0);

    reset_mid_run();
    back_to_back();

    for (int i = 0; i < 1000; i++) run_op(rnd_x(), 1'b1, 1'b0, 1'b0, 0, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end

endmodule
